store_queue: RTL and testbench
==============================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter SQ_SIZE, default 8, number of store entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, address/data width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port disp_valid  input  1  allocate one entry at tail this cycle.
REQ-006 SHALL have port disp_sq_idx  output  $clog2(SQ_SIZE)+1  current tail pointer incl. wrap bit; checkpointed by dispatch and returned by squash.
REQ-007 SHALL have port sq_full  output  1  no free entry.
REQ-008 SHALL have port ex_valid  input  1  execute writes address/data into an entry.
REQ-009 SHALL have port ex_sq_idx  input  $clog2(SQ_SIZE)  target entry of ex write.
REQ-010 SHALL have ports ex_addr  input  XLEN; ex_data  input  XLEN; ex_size  input  2  (byte/half/word).
REQ-011 SHALL have port rob2sq_retire_en  input  1  level signal: ROB head is a complete store.
REQ-012 SHALL have ports squash_en  input  1; squash_tail  input  $clog2(SQ_SIZE)+1  restore tail to this value.
REQ-013 SHALL have ports mem_req_valid  output  1; mem_req_addr  output  XLEN; mem_req_data  output  XLEN; mem_req_size  output  2; mem_req_ready  input  1.
REQ-014 SHALL have port dcache_store_stall  output  1  ROB must not retire a store this cycle.

Function
REQ-015 SHALL implement a circular buffer with head/tail pointers carrying one extra wrap bit; empty = pointers equal; full = indices equal, wrap bits differ.
REQ-016 Each entry SHALL hold valid, filled, addr, data, size.
REQ-017 Dispatch: disp_valid & (~sq_full | pop this cycle) SHALL write valid=1, filled=0 at tail and increment tail next cycle; disp_valid while full with no pop SHALL be ignored.
REQ-018 Execute: ex_valid SHALL set filled=1 and store addr/data/size in entry ex_sq_idx only if that entry is valid; otherwise ignored.
REQ-019 Squash: squash_en SHALL set tail := squash_tail and clear valid of every entry from squash_tail up to old tail; squash has priority over same-cycle dispatch; head and a store in SEND SHALL be unaffected.
REQ-020 Commit FSM states IDLE, SEND.
REQ-021 IDLE -> SEND when rob2sq_retire_en & head valid & head filled; captures head entry into mem_req_* registers.
REQ-022 SEND: mem_req_valid=1, mem_req_* held stable until mem_req_ready.
REQ-023 SEND & mem_req_ready SHALL pop head (clear valid, head+1) and return to IDLE in the same edge; mem_req_valid deasserts next cycle.
REQ-024 rob2sq_retire_en while in SEND SHALL be ignored (same ROB store still held).
REQ-025 dcache_store_stall SHALL be combinational: (state==SEND) | (rob2sq_retire_en & (empty | ~head filled)).
REQ-026 Retire accepted in IDLE SHALL not raise stall in that cycle; stall rises the following cycle (one store in flight at a time).
REQ-027 Pointer arithmetic SHALL wrap modulo 2*SQ_SIZE; entry index = low $clog2(SQ_SIZE) bits.
REQ-028 Simultaneous dispatch and pop while full SHALL keep occupancy at SQ_SIZE and sq_full=1.
REQ-029 sq_full and disp_sq_idx SHALL reflect registered state only (no dependence on same-cycle inputs).

Reset
REQ-030 reset=0 SHALL immediately (asynchronously) clear all entries, head=tail=0, state=IDLE.
REQ-031 During reset: mem_req_valid=0, mem_req_addr/data/size=0, sq_full=0, disp_sq_idx=0, dcache_store_stall=0.
REQ-032 Reset asserted while in SEND SHALL abandon the request; no pop, mem_req_valid=0 immediately.

Verification
REQ-033 Fill: 8 dispatches after reset -> sq_full=1, disp_sq_idx=8 (wrap bit set, index 0); 9th dispatch ignored.
REQ-034 Commit: dispatch, ex write addr=0x100 data=0xDEAD size=2, retire_en=1 -> next cycle mem_req_valid=1 addr=0x100, stall=1; ready held low 3 cycles -> outputs stable; ready=1 -> head+1, mem_req_valid=0, stall=0.
REQ-035 Unfilled head: retire_en=1 with head filled=0 -> stall=1, mem_req_valid=0, FSM stays IDLE until ex write.
REQ-036 Squash: tail=5, squash_tail=2 with disp_valid=1 same cycle -> tail=2, entries 2-4 invalid, no allocation.
REQ-037 Wrap: 20 dispatch/commit cycles on SQ_SIZE=8 -> ordering preserved, mem addresses emerge in dispatch order, pointers wrap twice.
REQ-038 Async reset mid-SEND: reset=0 between edges -> mem_req_valid=0 and sq empty before next posedge.

Source files
------------

// File: rtl/store_queue.sv
// Store queue: circular buffer of dispatched stores, filled by execute and
// committed in order to memory, one request in flight at a time.
module store_queue #(
  parameter int SQ_SIZE = 8,
  parameter int XLEN    = 32,
  localparam int IW     = $clog2(SQ_SIZE)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            disp_valid,
  output logic [IW:0]     disp_sq_idx,
  output logic            sq_full,
  input  logic            ex_valid,
  input  logic [IW-1:0]   ex_sq_idx,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic [1:0]      ex_size,
  input  logic            rob2sq_retire_en,
  input  logic            squash_en,
  input  logic [IW:0]     squash_tail,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_data,
  output logic [1:0]      mem_req_size,
  input  logic            mem_req_ready,
  output logic            dcache_store_stall,
  output logic            commit_state
);

  // Memory handshake: a request is transferred on a posedge where
  // mem_req_valid and mem_req_ready are both high; until then addr/data/size
  // are held stable and valid is never withdrawn (except by reset).

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t state, state_nxt;

  logic [IW:0]        head, tail;
  logic [IW-1:0]      head_idx, tail_idx;
  logic [SQ_SIZE-1:0] ent_valid, ent_filled;
  logic [XLEN-1:0]    ent_addr [SQ_SIZE];
  logic [XLEN-1:0]    ent_data [SQ_SIZE];
  logic [1:0]         ent_size [SQ_SIZE];

  logic               empty, full, pop, disp_fire, ex_hit, commit_start;
  logic [IW:0]        squash_span;
  logic [IW-1:0]      squash_off;
  logic [SQ_SIZE-1:0] kill_mask, pop_mask, disp_mask;

  assign head_idx     = head[IW-1:0];
  assign tail_idx     = tail[IW-1:0];
  assign empty        = (head == tail);
  assign full         = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign pop          = (state == SEND) && mem_req_ready;
  assign disp_fire    = disp_valid && !squash_en && (!full || pop);
  assign ex_hit       = ex_valid && ent_valid[ex_sq_idx];
  assign commit_start = (state == IDLE) && rob2sq_retire_en &&
                        ent_valid[head_idx] && ent_filled[head_idx];

  assign disp_sq_idx  = tail;
  assign sq_full      = full;

  // Squash kills every entry whose distance from squash_tail is below the
  // distance from squash_tail to the current tail.
  assign squash_span = tail - squash_tail;

  always_comb begin
    kill_mask  = '0;
    squash_off = '0;
    if (squash_en) begin
      for (int i = 0; i < SQ_SIZE; i++) begin
        squash_off = IW'(i) - squash_tail[IW-1:0];
        if ({1'b0, squash_off} < squash_span) kill_mask[i] = 1'b1;
      end
    end
  end

  assign pop_mask  = pop       ? (SQ_SIZE'(1) << head_idx) : '0;
  assign disp_mask = disp_fire ? (SQ_SIZE'(1) << tail_idx) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop) head <= head + (IW+1)'(1);
      if (squash_en)      tail <= squash_tail;
      else if (disp_fire) tail <= tail + (IW+1)'(1);
    end
  end

  // Dispatch is applied last so a refill of the slot popped this cycle wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid  <= '0;
      ent_filled <= '0;
    end else begin
      ent_valid <= (ent_valid & ~pop_mask & ~kill_mask) | disp_mask;
      if (ex_hit)    ent_filled[ex_sq_idx] <= 1'b1;
      if (disp_fire) ent_filled[tail_idx]  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SQ_SIZE; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_size[i] <= '0;
      end
    end else if (ex_hit) begin
      ent_addr[ex_sq_idx] <= ex_addr;
      ent_data[ex_sq_idx] <= ex_data;
      ent_size[ex_sq_idx] <= ex_size;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_size <= '0;
    end else if (commit_start) begin
      mem_req_addr <= ent_addr[head_idx];
      mem_req_data <= ent_data[head_idx];
      mem_req_size <= ent_size[head_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit_start) state_nxt = SEND;
      SEND:    if (mem_req_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is gated by reset so it reads low while the block is held in reset.
  always_comb begin
    mem_req_valid      = (state == SEND);
    commit_state       = state;
    dcache_store_stall = reset && ((state == SEND) ||
                         (rob2sq_retire_en && (empty || !ent_filled[head_idx])));
  end

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed fill/commit/squash/reset
// scenarios plus a randomised wrap-around run checked by a scoreboard.
module tb_store_queue;
  localparam int SQ_SIZE = 8;
  localparam int XLEN    = 32;
  localparam int IW      = 3;
  localparam int W       = 2 * XLEN + 2;

  logic            clock, reset;
  logic            disp_valid;
  logic [IW:0]     disp_sq_idx;
  logic            sq_full;
  logic            ex_valid;
  logic [IW-1:0]   ex_sq_idx;
  logic [XLEN-1:0] ex_addr, ex_data;
  logic [1:0]      ex_size;
  logic            rob2sq_retire_en;
  logic            squash_en;
  logic [IW:0]     squash_tail;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr, mem_req_data;
  logic [1:0]      mem_req_size;
  logic            mem_req_ready;
  logic            dcache_store_stall;
  logic            commit_state;

  store_queue #(.SQ_SIZE(SQ_SIZE), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_sq_idx(disp_sq_idx), .sq_full(sq_full),
    .ex_valid(ex_valid), .ex_sq_idx(ex_sq_idx), .ex_addr(ex_addr),
    .ex_data(ex_data), .ex_size(ex_size),
    .rob2sq_retire_en(rob2sq_retire_en),
    .squash_en(squash_en), .squash_tail(squash_tail),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
    .mem_req_ready(mem_req_ready),
    .dcache_store_stall(dcache_store_stall), .commit_state(commit_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [IW:0]  tail_m;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Retire the (filled) head store and complete its request with random ready.
  task automatic commit_one();
    bit hs;
    hs = 1'b0;
    rob2sq_retire_en = 1'b1;
    #1;
    check("stall_accept", dcache_store_stall, 0);
    tick();
    rob2sq_retire_en = 1'b0;
    check("send_state", commit_state, 1);
    for (int n = 0; n < 40 && !hs; n++) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      #1;
      hs = mem_req_valid && mem_req_ready;
      tick();
    end
    mem_req_ready = 1'b0;
    check("commit_hs", hs, 1);
  endtask

  // scoreboard / request monitor
  logic         hold_v;
  logic [W-1:0] hold_req;
  logic [W-1:0] front;
  initial hold_v = 1'b0;

  always @(negedge clock) begin
    if (mem_req_valid) begin
      if (hold_v) check("req_stable", {mem_req_addr, mem_req_data, mem_req_size}, hold_req);
      if (mem_req_ready) begin
        check("sb_nonempty", W'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          front = exp_q.pop_front();
          check("req_order", {mem_req_addr, mem_req_data, mem_req_size}, front);
        end
      end
      hold_v   = !mem_req_ready;
      hold_req = {mem_req_addr, mem_req_data, mem_req_size};
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic [XLEN-1:0] wa [3];
  logic [XLEN-1:0] wd [3];
  logic [1:0]      ws [3];
  logic [IW-1:0]   widx [3];
  int              done, nb;

  initial begin
    disp_valid = 0; ex_valid = 0; ex_sq_idx = '0; ex_addr = '0; ex_data = '0;
    ex_size = '0; squash_en = 0; squash_tail = '0; mem_req_ready = 0;
    rob2sq_retire_en = 1'b1;
    reset = 1'b0;
    tail_m = '0;

    // reset state, with retire_en high to show stall stays low in reset
    tick(); tick();
    check("rst_valid", mem_req_valid, 0);
    check("rst_addr", mem_req_addr, 0);
    check("rst_data", mem_req_data, 0);
    check("rst_size", mem_req_size, 0);
    check("rst_full", sq_full, 0);
    check("rst_idx", disp_sq_idx, 0);
    check("rst_stall", dcache_store_stall, 0);
    check("rst_state", commit_state, 0);
    rob2sq_retire_en = 1'b0;
    reset = 1'b1;
    tick();

    // fill to capacity, then one ignored dispatch
    disp_valid = 1'b1;
    for (int i = 0; i < SQ_SIZE; i++) begin
      check("fill_idx", disp_sq_idx, i);
      check("fill_notfull", sq_full, 0);
      tick();
    end
    check("full_flag", sq_full, 1);
    check("full_idx", disp_sq_idx, 8);
    tick();
    disp_valid = 1'b0;
    check("ninth_ignored", disp_sq_idx, 8);
    check("ninth_full", sq_full, 1);

    // unfilled head: stall, stay idle
    rob2sq_retire_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_unfilled", dcache_store_stall, 1);
      check("idle_unfilled", commit_state, 0);
      check("novalid_unfilled", mem_req_valid, 0);
      tick();
    end

    // commit of 0x100/0xDEAD with ready held low 3 cycles
    ex_valid = 1'b1; ex_sq_idx = 0; ex_addr = 32'h100; ex_data = 32'hDEAD; ex_size = 2'd2;
    exp_q.push_back({32'h100, 32'hDEAD, 2'd2});
    #1;
    check("stall_ex_cycle", dcache_store_stall, 1);
    tick();
    ex_valid = 1'b0;
    #1;
    check("stall_accept_idle", dcache_store_stall, 0);
    check("idle_accept", commit_state, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, 32'h100);
      check("req_data", mem_req_data, 32'hDEAD);
      check("req_size", mem_req_size, 2);
      check("req_stall", dcache_store_stall, 1);
      tick();
    end
    // pop and dispatch together while full
    mem_req_ready = 1'b1; disp_valid = 1'b1; rob2sq_retire_en = 1'b0;
    #1;
    check("full_pop", sq_full, 1);
    tick();
    mem_req_ready = 1'b0; disp_valid = 1'b0;
    check("pop_valid", mem_req_valid, 0);
    check("pop_stall", dcache_store_stall, 0);
    check("pop_full", sq_full, 1);
    check("pop_idx", disp_sq_idx, 9);
    check("pop_state", commit_state, 0);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst2_idx", disp_sq_idx, 0);

    // squash tail 5 -> 2 with a same-cycle dispatch
    disp_valid = 1'b1;
    repeat (5) tick();
    squash_en = 1'b1; squash_tail = 4'd2;
    check("pre_squash_idx", disp_sq_idx, 5);
    tick();
    squash_en = 1'b0; disp_valid = 1'b0;
    check("squash_idx", disp_sq_idx, 2);
    check("squash_full", sq_full, 0);
    tail_m = 4'd2;
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_sq_idx = (i == 2) ? 3'd3 : 3'(i);
      ex_addr   = 32'hA0 + 32'(i);
      ex_data   = 32'h5000 + 32'(i);
      ex_size   = 2'(i);
      if (i < 2) exp_q.push_back({ex_addr, ex_data, ex_size});
      tick();
    end
    ex_valid = 1'b0;
    commit_one();
    commit_one();
    rob2sq_retire_en = 1'b1;
    #1;
    check("empty_stall", dcache_store_stall, 1);
    tick();
    check("empty_idle", commit_state, 0);
    check("empty_novalid", mem_req_valid, 0);
    rob2sq_retire_en = 1'b0;

    // 20 stores in random batches; pointers pass through 8 and 16
    done = 0;
    while (done < 20) begin
      nb = $urandom_range(1, 3);
      if (nb > 20 - done) nb = 20 - done;
      for (int j = 0; j < nb; j++) begin
        wa[j] = $urandom; wd[j] = $urandom; ws[j] = 2'($urandom_range(0, 2));
        widx[j] = tail_m[IW-1:0];
        exp_q.push_back({wa[j], wd[j], ws[j]});
        disp_valid = 1'b1;
        check("wrap_idx", disp_sq_idx, tail_m);
        tick();
        disp_valid = 1'b0;
        tail_m = tail_m + 1'b1;
      end
      for (int j = nb - 1; j >= 0; j--) begin
        ex_valid = 1'b1; ex_sq_idx = widx[j];
        ex_addr = wa[j]; ex_data = wd[j]; ex_size = ws[j];
        tick();
      end
      ex_valid = 1'b0;
      for (int j = 0; j < nb; j++) commit_one();
      done += nb;
    end
    check("wrap_tail", disp_sq_idx, tail_m);
    check("wrap_tail_abs", disp_sq_idx, 6);
    check("wrap_notfull", sq_full, 0);

    // asynchronous reset while a request is outstanding
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    ex_valid = 1'b1; ex_sq_idx = tail_m[IW-1:0]; ex_addr = 32'h5A5A; ex_data = 32'h77; ex_size = 2'd1;
    tick();
    ex_valid = 1'b0;
    rob2sq_retire_en = 1'b1;
    tick();
    rob2sq_retire_en = 1'b0;
    check("arst_pre_valid", mem_req_valid, 1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", mem_req_valid, 0);
    check("arst_addr", mem_req_addr, 0);
    check("arst_stall", dcache_store_stall, 0);
    check("arst_full", sq_full, 0);
    check("arst_idx", disp_sq_idx, 0);
    check("arst_state", commit_state, 0);
    tick();
    reset = 1'b1;
    tick();
    check("arst_after_idx", disp_sq_idx, 0);
    check("arst_after_valid", mem_req_valid, 0);

    check("sb_drained", W'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
